// File: rtl/status_led_driver_pkg.sv
// Shared definitions for the multi-channel status LED driver: mode encodings,
// per-phase pattern masks and the pattern lookup used by every channel.
package status_led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_PULSE = 2'b11
    } led_mode_t;

    localparam int PHASE_W = 4;

    // Bit p of each mask is the LED level while the frame sits at phase p.
    localparam logic [15:0] BLINK_MASK = 16'h00FF;
    localparam logic [15:0] PULSE_MASK = 16'h0005;

    function automatic logic pattern_bit(input logic [1:0] mode,
                                         input logic [PHASE_W-1:0] phase);
        logic level;
        level = 1'b0;
        case (led_mode_t'(mode))
            MODE_OFF:   level = 1'b0;
            MODE_ON:    level = 1'b1;
            MODE_BLINK: level = BLINK_MASK[phase];
            MODE_PULSE: level = PULSE_MASK[phase];
            default:    level = 1'b0;
        endcase
        return level;
    endfunction

endpackage

// File: rtl/status_led_driver_tick_gen.sv
// Pattern timebase shared by all LED channels: tick prescaler, 16-step phase
// counter, frame_start pulse on the 15->0 wrap, and synchronous realignment.
module led_tick_gen
    import status_led_pkg::*;
#(
    parameter int TICK_DIV = 3125000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sync_restart,
    output logic               tick,
    output logic [PHASE_W-1:0] phase,
    output logic               frame_start
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             raw_tick;

    assign raw_tick = (div_cnt == DIV_LAST);
    // A tick landing in a restart cycle is dropped everywhere, stretch included.
    assign tick     = raw_tick & ~sync_restart;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt     <= '0;
            phase       <= '0;
            frame_start <= 1'b0;
        end else if (sync_restart) begin
            div_cnt     <= '0;
            phase       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= raw_tick && (phase == PHASE_W'(15));
            if (raw_tick) begin
                div_cnt <= '0;
                phase   <= phase + PHASE_W'(1);
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/status_led_driver.sv
// N-channel status LED driver: per-channel pattern, activity-stretch inversion
// overlay and global PWM dimming, all registered onto the LED pins.
module status_led_driver
    import status_led_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int TICK_DIV = 3125000,
    parameter int STRETCH  = 2,
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2*N_CH-1:0]   mode,
    input  logic [N_CH-1:0]     act_in,
    input  logic [PWM_BITS-1:0] brightness,
    input  logic                sync_restart,
    output logic [N_CH-1:0]     led_out,
    output logic                frame_start
);

    localparam int STR_W = $clog2(STRETCH + 1);
    localparam logic [STR_W-1:0] STR_LOAD = STR_W'(STRETCH);

    logic               tick;
    logic [PHASE_W-1:0] phase;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic               pwm_on;
    logic [N_CH-1:0]    led_next;

    led_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .sync_restart(sync_restart),
        .tick        (tick),
        .phase       (phase),
        .frame_start (frame_start)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    // Full-scale brightness must be solid on, which the compare alone cannot give.
    assign pwm_on = (brightness == '1) || (pwm_cnt < brightness);

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic [STR_W-1:0] stretch;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stretch <= '0;
            end else if (act_in[g]) begin
                stretch <= STR_LOAD;
            end else if (tick && (stretch != '0)) begin
                stretch <= stretch - STR_W'(1);
            end
        end

        assign led_next[g] = (pattern_bit(mode[2*g +: 2], phase) ^ (stretch != '0)) & pwm_on;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_out <= '0;
        end else begin
            led_out <= led_next;
        end
    end

endmodule
